uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_tx` transmitter between `Requesters` byte sources. A requester keeps the grant for a whole message, so bytes from different sources never interleave on the line. A lock ends on a byte flagged `last`, or when the granted source goes idle too long. The arbiter sits between the sources and the `uart_tx` `valid_i/ready_o/data_i` port and adds one registered output stage.

---
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin, message-locked arbiter sharing one uart_tx between
//            several byte sources, with one registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
   parameter int Requesters  = 4,
   parameter int IdleTimeout = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [Requesters-1:0]   req_valid_i,
   input  logic [Requesters-1:0]   req_last_i,
   input  logic [8*Requesters-1:0] req_data_i,
   output logic [Requesters-1:0]   req_ready_o,
   output logic                    tx_valid_o,
   output logic [7:0]              tx_data_o,
   input  logic                    tx_ready_i,
   output logic [Requesters-1:0]   grant_o,
   output logic                    busy_o
);

   localparam int          c_PTR_W     = (Requesters > 1) ? $clog2(Requesters) : 1;
   localparam logic [15:0] c_IDLE_LAST = 16'(IdleTimeout - 1);

   typedef enum logic [0:0] {
      ST_ARB    = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [c_PTR_W-1:0]    r_ptr;
   logic [c_PTR_W-1:0]    r_owner;
   logic [c_PTR_W-1:0]    w_sel;
   logic [c_PTR_W-1:0]    w_ptr_nxt;
   logic [Requesters-1:0] r_grant;
   logic [Requesters-1:0] w_sel_onehot;
   logic                  r_tx_valid;
   logic [7:0]            r_tx_data;
   logic [15:0]           r_idle;
   logic                  w_found;
   logic                  w_own_valid;
   logic                  w_own_last;
   logic [7:0]            w_own_data;
   logic                  w_slot_free;
   logic                  w_src_xfer;
   logic                  w_out_xfer;
   logic                  w_timeout;
   logic                  w_release;

   // Owner-side view of the request bus and the single ready that may be high.
   always_comb begin
      w_own_valid = 1'b0;
      w_own_last  = 1'b0;
      w_own_data  = 8'h00;
      req_ready_o = '0;
      w_slot_free = !r_tx_valid || tx_ready_i;
      for (int k = 0; k < Requesters; k++) begin
         if (r_owner == c_PTR_W'(k)) begin
            w_own_valid    = req_valid_i[k];
            w_own_last     = req_last_i[k];
            w_own_data     = req_data_i[8*k +: 8];
            req_ready_o[k] = (r_state == ST_LOCKED) && w_slot_free;
         end
      end
   end

   // First valid source at or after the pointer, wrapping around.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int i = 0; i < Requesters; i++) begin
         for (int k = 0; k < Requesters; k++) begin
            if (!w_found && req_valid_i[k] && (((int'(r_ptr) + i) % Requesters) == k)) begin
               w_found = 1'b1;
               w_sel   = c_PTR_W'(k);
            end
         end
      end
   end

   always_comb begin
      w_sel_onehot = '0;
      for (int k = 0; k < Requesters; k++) begin
         w_sel_onehot[k] = (w_sel == c_PTR_W'(k));
      end
   end

   assign w_ptr_nxt  = (r_owner == c_PTR_W'(Requesters - 1)) ? '0 : r_owner + c_PTR_W'(1);
   assign w_src_xfer = (r_state == ST_LOCKED) && w_own_valid && w_slot_free;
   assign w_out_xfer = r_tx_valid && tx_ready_i;
   assign w_timeout  = (IdleTimeout != 0) && (r_state == ST_LOCKED) && !w_own_valid
                       && (r_idle == c_IDLE_LAST);
   assign w_release  = (w_src_xfer && w_own_last) || w_timeout;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ARB:    if (w_found)   w_state_nxt = ST_LOCKED;
         ST_LOCKED: if (w_release) w_state_nxt = ST_ARB;
         default:   w_state_nxt = ST_ARB;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_ARB;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ptr      <= '0;
         r_owner    <= '0;
         r_grant    <= '0;
         r_idle     <= '0;
         r_tx_valid <= 1'b0;
         r_tx_data  <= 8'h00;
      end else begin
         if (r_state == ST_ARB) begin
            if (w_found) begin
               r_owner <= w_sel;
               r_grant <= w_sel_onehot;
               r_idle  <= '0;
            end
         end else begin
            r_idle <= w_own_valid ? 16'd0 : r_idle + 16'd1;
            if (w_release) begin
               r_grant <= '0;
               r_ptr   <= w_ptr_nxt;
            end
         end
         // The output stage drains independently of the lock state.
         if (w_src_xfer) begin
            r_tx_data  <= w_own_data;
            r_tx_valid <= 1'b1;
         end else if (w_out_xfer) begin
            r_tx_valid <= 1'b0;
         end
      end
   end

   assign tx_valid_o = r_tx_valid;
   assign tx_data_o  = r_tx_data;
   assign grant_o    = r_grant;
   assign busy_o     = (r_state == ST_LOCKED) || r_tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the arbitration rules.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int TO = 8;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic [N-1:0]   req_valid, req_last;
   logic [8*N-1:0] req_data;
   logic           tx_ready;
   logic [N-1:0]   req_ready, grant;
   logic           tx_valid, busy;
   logic [7:0]     tx_data;
   logic [N-1:0]   z_req_ready, z_grant;
   logic           z_tx_valid, z_busy;
   logic [7:0]     z_tx_data;

   uart_tx_arbiter #(.Requesters(N), .IdleTimeout(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid), .req_last_i(req_last),
      .req_data_i(req_data), .req_ready_o(req_ready), .tx_valid_o(tx_valid),
      .tx_data_o(tx_data), .tx_ready_i(tx_ready), .grant_o(grant), .busy_o(busy));

   uart_tx_arbiter #(.Requesters(N), .IdleTimeout(0)) dut_nto (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid), .req_last_i(req_last),
      .req_data_i(req_data), .req_ready_o(z_req_ready), .tx_valid_o(z_tx_valid),
      .tx_data_o(z_tx_data), .tx_ready_i(tx_ready), .grant_o(z_grant), .busy_o(z_busy));

   always #5 clk_i = ~clk_i;

   int         n_pass  = 0;
   int         n_total = 0;
   logic [8:0] sq[N][$];
   logic [7:0] got[$];
   logic [3:0] gseq[$];
   logic [N-1:0] last_g;
   int         m_owner, m_ptr, m_idle;
   logic [7:0] m_q[$];
   logic [N-1:0] pend;
   logic [7:0] pend_d[N];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] pack_got();
      logic [63:0] v = '0;
      foreach (got[i]) v = {v[55:0], got[i]};
      return v;
   endfunction

   function automatic logic [63:0] pack_gseq();
      logic [63:0] v = '0;
      foreach (gseq[i]) v = {v[59:0], gseq[i]};
      return v;
   endfunction

   function automatic bit all_idle();
      bit e = (m_owner < 0) && (m_q.size() == 0);
      for (int k = 0; k < N; k++) if (sq[k].size() != 0) e = 0;
      return e;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_idle  = 0;
      m_q.delete();
      pend    = '0;
      last_g  = '0;
   endtask

   // Present the head of each source queue; a pending byte must persist.
   task automatic drive();
      for (int k = 0; k < N; k++) begin
         if (sq[k].size() != 0) begin
            req_valid[k]         = 1'b1;
            req_last[k]          = sq[k][0][8];
            req_data[8*k +: 8]   = sq[k][0][7:0];
         end else begin
            req_valid[k]         = 1'b0;
            req_last[k]          = 1'b0;
            req_data[8*k +: 8]   = 8'h00;
         end
         if (pend[k]) chk("src_hold", {req_valid[k], req_data[8*k +: 8]}, {1'b1, pend_d[k]});
      end
   endtask

   task automatic model_cycle();
      logic [N-1:0] eg, er;
      logic src, rel;
      int   kk;
      eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      er = (m_owner >= 0 && (m_q.size() == 0 || tx_ready)) ? eg : '0;
      chk("grant", grant, eg);
      chk("tx_valid", tx_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);
      chk("req_ready", req_ready, er);
      chk("busy", busy, (m_owner >= 0) || (m_q.size() != 0));
      if (grant != '0 && grant != last_g) gseq.push_back(grant);
      last_g = grant;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      src = 1'b0;
      if (m_owner >= 0) src = req_valid[m_owner] && (er != '0);
      for (int k = 0; k < N; k++) begin
         pend[k]   = req_valid[k] && !(src && k == m_owner);
         pend_d[k] = req_data[8*k +: 8];
      end
      if (m_q.size() != 0 && tx_ready) void'(m_q.pop_front());
      if (src) begin
         m_q.push_back(req_data[8*m_owner +: 8]);
         void'(sq[m_owner].pop_front());
      end
      if (m_owner < 0) begin
         for (int i = 0; i < N; i++) begin
            kk = (m_ptr + i) % N;
            if (m_owner < 0 && req_valid[kk]) begin
               m_owner = kk;
               m_idle  = 0;
            end
         end
      end else begin
         rel    = (src && req_last[m_owner]) ||
                  (TO != 0 && !req_valid[m_owner] && m_idle == TO - 1);
         m_idle = req_valid[m_owner] ? 0 : m_idle + 1;
         if (rel) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end
      end
   endtask

   task automatic cyc();
      drive();
      #1;
      model_cycle();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      #2 rst_i = 1'b1;
      #1 chk("rst_async_out", {grant, tx_valid, tx_data, req_ready, busy}, '0);
      @(negedge clk_i);
      for (int k = 0; k < N; k++) sq[k].delete();
      model_reset();
      got.delete();
      gseq.delete();
      drive();
      rst_i = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n, pushed, lowrun, len, k;
      bit  bp_ok;
      rst_i = 1'b1; tx_ready = 1'b1;
      req_valid = '0; req_last = '0; req_data = '0;
      model_reset();
      #3 chk("reset_state", {grant, tx_valid, tx_data, req_ready, busy}, '0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Single byte, then pointer advanced to 1
      sq[0].push_back({1'b1, 8'hA5});
      cyc(); chk("single_grant", grant, 4'b0001);
      cyc(); chk("single_tx", {tx_valid, tx_data}, {1'b1, 8'hA5});
      cyc();
      sq[0].push_back({1'b1, 8'h11});
      sq[1].push_back({1'b1, 8'h22});
      repeat (10) cyc();
      chk("ptr_after_single", pack_got(), 64'hA52211);

      // Round-robin order
      do_reset();
      sq[0].push_back({1'b1, 8'h10});
      sq[2].push_back({1'b1, 8'h30});
      repeat (10) cyc();
      sq[0].push_back({1'b1, 8'h40});
      sq[1].push_back({1'b1, 8'h41});
      sq[3].push_back({1'b1, 8'h43});
      repeat (14) cyc();
      chk("rr_order", pack_got(), 64'h1030434041);

      // Message lock with a competing source
      do_reset();
      sq[0].push_back({1'b1, 8'h01});
      repeat (5) cyc();
      sq[1].push_back({1'b0, 8'h48});
      sq[1].push_back({1'b1, 8'h49});
      sq[0].push_back({1'b1, 8'h50});
      repeat (12) cyc();
      chk("lock_bytes", pack_got(), 64'h01484950);
      chk("lock_grants", pack_gseq(), 64'h121);

      // Backpressure for 100 cycles
      tx_ready = 1'b0;
      sq[2].push_back({1'b1, 8'h77});
      sq[3].push_back({1'b1, 8'h88});
      cyc(); cyc();
      bp_ok = 1'b1;
      for (int i = 0; i < 100; i++) begin
         cyc();
         bp_ok = bp_ok && (tx_valid === 1'b1) && (tx_data === 8'h77) && (req_ready === 4'b0000);
      end
      chk("bp_stable", bp_ok, 1);
      n = got.size();
      tx_ready = 1'b1;
      cyc();
      chk("bp_one_xfer", got.size() - n, 1);
      chk("bp_xfer_data", got[got.size()-1], 8'h77);
      chk("bp_next_byte", {tx_valid, tx_data}, {1'b1, 8'h88});
      cyc();

      // Idle timeout
      do_reset();
      sq[2].push_back({1'b0, 8'h21});
      sq[3].push_back({1'b1, 8'h31});
      cyc(); chk("to_grant", grant, 4'b0100);
      cyc();
      n = 0;
      while (grant === 4'b0100 && n < 30) begin
         cyc();
         n++;
      end
      chk("to_idle_cycles", n, 8);
      chk("nto_hold", z_grant, 4'b0100);
      cyc(); chk("to_next_grant", grant, 4'b1000);
      repeat (20) cyc();
      chk("nto_hold_long", z_grant, 4'b0100);

      // Reset mid-message, pointer moved to 2 beforehand
      sq[1].push_back({1'b1, 8'h5A});
      repeat (6) cyc();
      tx_ready = 1'b0;
      sq[2].push_back({1'b0, 8'h61});
      sq[2].push_back({1'b1, 8'h62});
      cyc(); cyc();
      chk("mid_pre_reset", {busy, tx_valid, grant}, {1'b1, 1'b1, 4'b0100});
      do_reset();
      tx_ready = 1'b1;
      sq[3].push_back({1'b1, 8'hB3});
      sq[1].push_back({1'b1, 8'hB1});
      repeat (10) cyc();
      chk("post_reset_order", pack_got(), 64'hB1B3);

      // Randomized traffic
      got.delete();
      pushed = 0;
      lowrun = 0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 5) == 0) begin
            k = $urandom_range(0, N-1);
            if (sq[k].size() < 6) begin
               len = $urandom_range(1, 3);
               for (int j = 0; j < len; j++) sq[k].push_back({j == len - 1, 8'($urandom)});
               pushed += len;
            end
         end
         if (lowrun > 0) begin
            tx_ready = 1'b0;
            lowrun--;
         end else begin
            tx_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) lowrun = $urandom_range(5, 20);
         end
         cyc();
      end
      tx_ready = 1'b1;
      n = 0;
      while (!all_idle() && n < 300) begin
         cyc();
         n++;
      end
      chk("rand_drained", n < 300, 1);
      chk("rand_byte_count", got.size(), pushed);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
